// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute hazard signals between the pipeline and the stall controller.
// The slave modport is the controller side; the master modport is the pipeline (or bench) side.
interface hazard_stall_ctrl_if;
    logic [3:0] IF_ID_op1;
    logic [3:0] IF_ID_op2;
    logic [3:0] ID_EX_op1;
    logic       ID_EX_memRead;
    logic       ID_EX_regWrite;
    logic       muldiv_start;
    logic       branch_taken;
    logic       PCWrite;
    logic       IF_ID_write;
    logic       ID_EX_bubble;
    logic       IF_ID_flush;
    logic       hazard_busy;
    logic [7:0] stall_count;

    modport slave (
        input  IF_ID_op1, IF_ID_op2, ID_EX_op1, ID_EX_memRead, ID_EX_regWrite,
               muldiv_start, branch_taken,
        output PCWrite, IF_ID_write, ID_EX_bubble, IF_ID_flush, hazard_busy, stall_count
    );

    modport master (
        output IF_ID_op1, IF_ID_op2, ID_EX_op1, ID_EX_memRead, ID_EX_regWrite,
               muldiv_start, branch_taken,
        input  PCWrite, IF_ID_write, ID_EX_bubble, IF_ID_flush, hazard_busy, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes and multi-cycle muldiv holds.
// Define MULDIV_STALL_EN to build the MULDIV_WAIT state and its wait counter.
module hazard_stall_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input logic               clk,
    input logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic {
        RUN,
        MULDIV_WAIT
    } state_t;

    if (MULDIV_LAT < 2 || MULDIV_LAT > 7) begin : g_latCheck
        $error("MULDIV_LAT must be in 2..7");
    end

    state_t     r_state;
    logic       r_hazardBusy;
    logic [7:0] r_stallCount;
`ifdef MULDIV_STALL_EN
    logic [2:0] r_waitCnt;
`endif

    logic w_pcWrite;
    logic w_ifIdWrite;
    logic w_idExBubble;
    logic w_ifIdFlush;
    wire  w_loadUse = bus.ID_EX_memRead & bus.ID_EX_regWrite & (bus.ID_EX_op1 != 4'd0) &
                      ((bus.ID_EX_op1 == bus.IF_ID_op1) | (bus.ID_EX_op1 == bus.IF_ID_op2));

    // Zero-latency pipeline controls; reset holds the pipe frozen with a bubble in EX.
    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifIdWrite  = 1'b1;
        w_idExBubble = 1'b0;
        w_ifIdFlush  = 1'b0;
        if (!rst_n) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExBubble = 1'b1;
        end else if (bus.branch_taken) begin
            w_ifIdFlush  = 1'b1;
            w_idExBubble = 1'b1;
        end else if (r_state == MULDIV_WAIT || w_loadUse) begin
            w_pcWrite    = 1'b0;
            w_ifIdWrite  = 1'b0;
            w_idExBubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_hazardBusy <= 1'b0;
            r_stallCount <= 8'd0;
`ifdef MULDIV_STALL_EN
            r_waitCnt    <= 3'd0;
`endif
        end else begin
            if (!w_pcWrite && r_stallCount != 8'hFF) begin
                r_stallCount <= r_stallCount + 8'd1;
            end
            case (r_state)
                RUN: begin
`ifdef MULDIV_STALL_EN
                    if (bus.muldiv_start && !bus.branch_taken && !w_loadUse) begin
                        r_state      <= MULDIV_WAIT;
                        r_hazardBusy <= 1'b1;
                        r_waitCnt    <= 3'(MULDIV_LAT - 1);
                    end
`endif
                end
                MULDIV_WAIT: begin
`ifdef MULDIV_STALL_EN
                    // A taken branch squashes the muldiv, so the wait ends early.
                    if (bus.branch_taken || r_waitCnt == 3'd1) begin
                        r_state      <= RUN;
                        r_hazardBusy <= 1'b0;
                        r_waitCnt    <= 3'd0;
                    end else begin
                        r_waitCnt    <= r_waitCnt - 3'd1;
                    end
`else
                    r_state      <= RUN;
                    r_hazardBusy <= 1'b0;
`endif
                end
                default: begin
                    r_state      <= RUN;
                    r_hazardBusy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCWrite      = w_pcWrite;
    assign bus.IF_ID_write  = w_ifIdWrite;
    assign bus.ID_EX_bubble = w_idExBubble;
    assign bus.IF_ID_flush  = w_ifIdFlush;
    assign bus.hazard_busy  = r_hazardBusy;
    assign bus.stall_count  = r_stallCount;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Muldiv vectors follow MULDIV_STALL_EN.
module tb_hazard_stall_ctrl;

    typedef struct {
        string      name;
        logic [12:0] expVal;
    } expect_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    expect_t scoreQ[$];

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.MULDIV_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mkExp(input logic pcw, input logic ifw, input logic bub,
                                          input logic flush, input logic busy, input int stall);
        logic [7:0] s;
        s = 8'(stall);
        return {pcw, ifw, bub, flush, busy, s};
    endfunction

    // Drives one cycle of inputs just after the rising edge and records what that cycle must show.
    task automatic applyStimulus(input string name, input logic rst, input logic [3:0] op1,
                                 input logic [3:0] op2, input logic [3:0] exOp, input logic memRd,
                                 input logic regWr, input logic mulStart, input logic branch,
                                 input logic [12:0] expVal);
        expect_t e;
        @(posedge clk);
        #1;
        rst_n              = rst;
        bus.IF_ID_op1      = op1;
        bus.IF_ID_op2      = op2;
        bus.ID_EX_op1      = exOp;
        bus.ID_EX_memRead  = memRd;
        bus.ID_EX_regWrite = regWr;
        bus.muldiv_start   = mulStart;
        bus.branch_taken   = branch;
        e.name   = name;
        e.expVal = expVal;
        scoreQ.push_back(e);
    endtask

    task automatic idle(input string name, input logic [12:0] expVal);
        applyStimulus(name, 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, expVal);
    endtask

    task automatic checkOutput(input expect_t e);
        logic [12:0] act;
        act = {bus.PCWrite, bus.IF_ID_write, bus.ID_EX_bubble, bus.IF_ID_flush,
               bus.hazard_busy, bus.stall_count};
        checks++;
        if (act !== e.expVal) begin
            errors++;
            $display("[TB] FAIL %s: got pcw/ifw/bub/flush/busy=%b stall=%0d, want %b stall=%0d",
                     e.name, act[12:8], act[7:0], e.expVal[12:8], e.expVal[7:0]);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int waitCycles;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.IF_ID_op1 = 4'd0;
        bus.IF_ID_op2 = 4'd0;
        bus.ID_EX_op1 = 4'd0;
        bus.ID_EX_memRead = 1'b0;
        bus.ID_EX_regWrite = 1'b0;
        bus.muldiv_start = 1'b0;
        bus.branch_taken = 1'b0;

        applyStimulus("reset", 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(0, 0, 1, 0, 0, 0));
        idle("idle0", mkExp(1, 1, 0, 0, 0, 0));
        applyStimulus("loaduse_op2", 1'b1, 4'd2, 4'b1001, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, mkExp(0, 0, 1, 0, 0, 0));
        idle("after_loaduse", mkExp(1, 1, 0, 0, 0, 1));
        applyStimulus("r0_guard", 1'b1, 4'd0, 4'd7, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 1));
        applyStimulus("loaduse_op1", 1'b1, 4'd5, 4'd6, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, mkExp(0, 0, 1, 0, 0, 1));
        applyStimulus("no_regwrite", 1'b1, 4'd5, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2));
        applyStimulus("no_memread", 1'b1, 4'd5, 4'd6, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, mkExp(1, 1, 0, 0, 0, 2));
        applyStimulus("branch_over_lu", 1'b1, 4'd5, 4'd6, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, mkExp(1, 1, 1, 1, 0, 2));
        idle("after_branch", mkExp(1, 1, 0, 0, 0, 2));
`ifdef MULDIV_STALL_EN
        applyStimulus("md_start", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(1, 1, 0, 0, 0, 2));
        idle("md_wait1", mkExp(0, 0, 1, 0, 1, 2));
        idle("md_wait2", mkExp(0, 0, 1, 0, 1, 3));
        idle("md_wait3", mkExp(0, 0, 1, 0, 1, 4));
        idle("md_done", mkExp(1, 1, 0, 0, 0, 5));
        applyStimulus("md_vs_loaduse", 1'b1, 4'd4, 4'd2, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, mkExp(0, 0, 1, 0, 0, 5));
        idle("md_lu_stays_run", mkExp(1, 1, 0, 0, 0, 6));
        applyStimulus("md_vs_branch", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, mkExp(1, 1, 1, 1, 0, 6));
        idle("md_br_stays_run", mkExp(1, 1, 0, 0, 0, 6));
        applyStimulus("abort_start", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(1, 1, 0, 0, 0, 6));
        idle("abort_wait1", mkExp(0, 0, 1, 0, 1, 6));
        applyStimulus("abort_branch", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, mkExp(1, 1, 1, 1, 1, 7));
        idle("abort_run", mkExp(1, 1, 0, 0, 0, 7));
        applyStimulus("rst_md_start", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(1, 1, 0, 0, 0, 7));
        idle("rst_md_wait", mkExp(0, 0, 1, 0, 1, 7));
`else
        applyStimulus("md_ignored", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(1, 1, 0, 0, 0, 2));
        idle("md_ignored_next", mkExp(1, 1, 0, 0, 0, 2));
        applyStimulus("md_ignored_hold", 1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, mkExp(1, 1, 0, 0, 0, 2));
`endif
        applyStimulus("async_reset", 1'b0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, mkExp(0, 0, 1, 0, 0, 0));
        idle("post_reset_run", mkExp(1, 1, 0, 0, 0, 0));

        for (int i = 0; i < 300; i++) begin
            applyStimulus("saturate", 1'b1, 4'd8, 4'd2, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0,
                          mkExp(0, 0, 1, 0, 0, (i < 255) ? i : 255));
        end
        idle("saturated", mkExp(1, 1, 0, 0, 0, 255));

        waitCycles = 0;
        while (scoreQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        @(posedge clk);
        if (scoreQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", scoreQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
